// File: rtl/autoenc_pkg.sv
// Shared definitions for the stream demultiplexer: default payload width
// and the routing-mode encodings.
package autoenc_pkg;

    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic {
        MODE_ADDR = 1'b0,
        MODE_RR   = 1'b1
    } mode_e;

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: a full flag plus a data register with valid/ready.
// Build option: STREAM_DEMUX_HOLD_EN keeps the last data after a drain;
// otherwise the data register clears when the slot empties without refill.
module demux_slot #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // Load wins over drain so a same-cycle drain and refill leaves the slot full.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (valid && ready) begin
            valid <= 1'b0;
`ifndef STREAM_DEMUX_HOLD_EN
            data  <= '0;
`endif
        end
    end

endmodule

// File: rtl/stream_demux_n.sv
// Routes one input stream to N_OUT one-entry output slots, either addressed
// by sel or in round-robin order. Out-of-range addressed beats are dropped
// and flagged on sel_err one cycle later.
// Build option: STREAM_DEMUX_HOLD_EN (slot data held after drain).
module stream_demux_n
    import autoenc_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned SEL_W  = $clog2(N_OUT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    mode,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic                    sel_err
);

    localparam int unsigned SEL_SPAN = 1 << SEL_W;
    // One bit per encodable sel value, set where the channel exists.
    localparam logic [SEL_SPAN-1:0] SEL_OK = SEL_SPAN'({N_OUT{1'b1}});

    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] tgt;
    logic             rr_mode;
    logic             oor;
    logic             accept;
    logic [N_OUT-1:0] load;

    // Target selection and input handshake; dropped beats are always accepted.
    always_comb begin
        rr_mode  = (mode_e'(mode) == MODE_RR);
        tgt      = rr_mode ? rr_ptr : sel;
        oor      = !rr_mode && !SEL_OK[sel];
        in_ready = 1'b0;
        if (!rst) begin
            if (oor) begin
                in_ready = 1'b1;
            end else begin
                in_ready = !out_valid[tgt] || out_ready[tgt];
            end
        end
        accept = in_valid && in_ready;
    end

    // Round-robin pointer advances only on round-robin accepts and is held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept && rr_mode) begin
            if (rr_ptr == SEL_W'(N_OUT - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= rr_ptr + SEL_W'(1);
            end
        end
    end

    // One-cycle pulse for each dropped out-of-range beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept && oor;
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign load[k] = accept && !oor && (tgt == SEL_W'(k));

        demux_slot #(
            .DATA_W (DATA_W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .valid     (out_valid[k]),
            .data      (out_data[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Self-checking bench for stream_demux_n: directed scenarios plus randomized
// traffic against a behavioural slot/pointer model, and a 3-channel instance
// for out-of-range select handling.
module tb_stream_demux_n;

`ifdef STREAM_DEMUX_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [1:0]  sel;
    logic        mode;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [63:0] out_data;
    logic        sel_err;

    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_in_data;
    logic [1:0]  b_sel;
    logic        b_mode;
    logic [2:0]  b_out_valid;
    logic [2:0]  b_out_ready;
    logic [47:0] b_out_data;
    logic        b_sel_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: contents of each channel's slot and the rotation counter.
    bit          m_full [4];
    logic [15:0] m_data [4];
    int          m_rr;
    bit          m_err;

    stream_demux_n u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .sel       (sel),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .sel_err   (sel_err)
    );

    stream_demux_n #(.N_OUT(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .sel       (b_sel),
        .mode      (b_mode),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .sel_err   (b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = '0;
        end
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    // One clock: compare all outputs at the falling edge, then advance the model.
    task automatic step();
        int          t;
        bit          rdy;
        bit          acc;
        logic [3:0]  exp_ov;
        logic [63:0] exp_od;
        @(negedge clk);
        t   = mode ? m_rr : int'(sel);
        rdy = !rst && (!m_full[t] || out_ready[t]);
        for (int k = 0; k < 4; k++) begin
            exp_ov[k]           = m_full[k];
            exp_od[k*16 +: 16]  = m_data[k];
        end
        check("in_ready", 64'(in_ready), 64'(rdy));
        check("out_valid", 64'(out_valid), 64'(exp_ov));
        check("out_data", out_data, exp_od);
        check("sel_err", 64'(sel_err), 64'(m_err));
        acc = in_valid && rdy;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            m_err = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (acc && t == k) begin
                    m_full[k] = 1'b1;
                    m_data[k] = in_data;
                end else if (m_full[k] && out_ready[k]) begin
                    m_full[k] = 1'b0;
                    if (!HOLD) m_data[k] = '0;
                end
            end
            if (acc && mode) m_rr = (m_rr + 1) % 4;
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; sel = '0; mode = 1'b0; out_ready = '0;
        b_in_valid = 1'b0; b_in_data = '0; b_sel = '0; b_mode = 1'b0; b_out_ready = '1;
        model_reset();
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Addressed beats to each channel with all consumers ready.
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sel = 2'(i); in_data = 16'(16'h1111 * (i + 1));
            step();
            check("addr_data", 64'(out_data[i*16 +: 16]), 64'(16'h1111 * (i + 1)));
            check("addr_valid", 64'(out_valid[i]), 64'd1);
        end
        in_valid = 1'b0;
        step();

        // Backpressure on channel 2: hold, stall, then accept with no bubble.
        out_ready = 4'b1011; in_valid = 1'b1; sel = 2'd2; in_data = 16'hC001;
        step();
        check("bp_first", 64'(out_data[47:32]), 64'h C001);
        in_data = 16'hC002;
        step();
        check("bp_hold", 64'(out_data[47:32]), 64'h C001);
        check("bp_stall", 64'(out_valid[2]), 64'd1);
        out_ready = 4'hF;
        step();
        check("bp_second", 64'(out_data[47:32]), 64'h C002);
        in_valid = 1'b0;
        step();

        // Round-robin: six beats wrap over the four channels.
        mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = 16'(16'h00A0 + i);
            step();
            check("rr_data", 64'(out_data[(i % 4)*16 +: 16]), 64'(16'h00A0 + i));
            check("rr_valid", 64'(out_valid[i % 4]), 64'd1);
        end
        in_valid = 1'b0; mode = 1'b0;
        step();

        // Out-of-range select on the 3-channel instance.
        b_in_valid = 1'b1; b_sel = 2'd3; b_in_data = 16'hBEEF;
        #1;
        check("oor_ready", 64'(b_in_ready), 64'd1);
        step();
        b_in_valid = 1'b0;
        check("oor_err", 64'(b_sel_err), 64'd1);
        check("oor_valid", 64'(b_out_valid), 64'd0);
        step();
        check("oor_err_clr", 64'(b_sel_err), 64'd0);
        check("oor_valid2", 64'(b_out_valid), 64'd0);

        // Reset with every slot full and every consumer stalled.
        out_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sel = 2'(i); in_data = 16'(16'h7000 + i);
            step();
        end
        in_valid = 1'b0;
        check("full_all", 64'(out_valid), 64'hF);
        rst = 1'b1;
        step();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", out_data, 64'd0);
        rst = 1'b0;
        step();

        // Drain channel 1 without refill.
        in_valid = 1'b1; sel = 2'd1; in_data = 16'h5A5A;
        step();
        in_valid = 1'b0; out_ready = 4'b0010;
        step();
        check("drain_valid", 64'(out_valid[1]), 64'd0);
        check("drain_data", 64'(out_data[31:16]), HOLD ? 64'h5A5A : 64'h0);

        // Randomized traffic, mode flips and occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            sel       = 2'($urandom);
            out_ready = 4'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            step();
        end
        rst = 1'b0; in_valid = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
